// File: rtl/lfsr_pkg.sv
// Shared state encoding and LFSR helpers for the multi-candidate preamble decryptor.
package lfsr_pkg;

   localparam int unsigned MAXW = 32;
   localparam int unsigned MAXN = 32;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_READ_PRE = 3'd1;
   localparam state_t ST_READ_MSG = 3'd2;
   localparam state_t ST_FINISH   = 3'd3;
   localparam state_t ST_FAIL     = 3'd4;

   // Shift left, feed back the parity of the tapped bits, keep the low w bits.
   function automatic logic [MAXW-1:0] lfsr_step(input logic [MAXW-1:0] s,
                                                 input logic [MAXW-1:0] t,
                                                 input int unsigned     w);
      logic [MAXW-1:0] mask;
      mask = (MAXW'(1) << w) - MAXW'(1);
      return ((s << 1) | MAXW'(^(s & t))) & mask;
   endfunction

   function automatic int unsigned popcount(input logic [MAXN-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < MAXN; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   // Index of the lowest set bit; only meaningful when v is one-hot.
   function automatic int unsigned onehot_idx(input logic [MAXN-1:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = MAXN - 1; i >= 0; i--) begin
         if (v[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/lfsr_decrypt_engine_lfsr_n.sv
// One candidate LFSR. Loading consumes symbol 0, so the register holds the key
// for the symbol that arrives next.
module lfsr_n
   import lfsr_pkg::*;
#(
   parameter int unsigned LW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          load,
   input  logic [LW-1:0] taps,
   input  logic [LW-1:0] start,
   output logic [LW-1:0] state
);

   logic [LW-1:0] next_c;

   always_comb begin
      next_c = LW'(lfsr_step(MAXW'(load ? start : state), MAXW'(taps), LW));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          state <= '0;
      else if (load || en) state <= next_c;
   end

endmodule

// File: rtl/lfsr_decrypt_engine.sv
// Streams an encrypted message, picks the tap pattern that reproduces the known
// preamble among NTAP parallel LFSRs, and writes back the decrypted payload.
module lfsr_decrypt_engine
   import lfsr_pkg::*;
#(
   parameter int unsigned   DW       = 8,
   parameter int unsigned   AW       = 8,
   parameter int unsigned   LW       = 6,
   parameter int unsigned   NTAP     = 6,
   parameter int unsigned   PRE_LEN  = 7,
   parameter int unsigned   MSG_LEN  = 64,
   parameter logic [AW-1:0] SRC_BASE = AW'(64),
   parameter logic [AW-1:0] DST_BASE = AW'(0),
   parameter logic [DW-1:0] PRE_CHAR = DW'(8'h5F)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [NTAP*LW-1:0]       taps,
   output logic [AW-1:0]            raddr,
   input  logic [DW-1:0]            rdata,
   output logic [AW-1:0]            waddr,
   output logic [DW-1:0]            wdata,
   output logic                     wr_en,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [((NTAP > 1) ? $clog2(NTAP) : 1)-1:0] sel_idx
);

   localparam int unsigned IW = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam int unsigned CW = $clog2(MSG_LEN + 1);
   localparam logic [LW-1:0] PRE_KEY = PRE_CHAR[LW-1:0];

   state_t              state_q, state_d;
   logic                rd_act_q, rd_act_d;
   logic                sym_vld_q, sym_vld_d;
   logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]       sym_cnt_q, sym_cnt_d;
   logic [NTAP-1:0]     alive_q, alive_d;
   logic [NTAP*LW-1:0]  taps_q, taps_d;

   logic [AW-1:0]       raddr_d, waddr_d;
   logic [DW-1:0]       wdata_d;
   logic                wr_en_d, busy_d, done_d, err_d;
   logic [IW-1:0]       sel_idx_d;

   logic [LW-1:0]       lfsr_state [NTAP];
   logic [LW-1:0]       obs_key_c;
   logic [LW-1:0]       key_sel_c;
   logic [NTAP-1:0]     match_c, surv_c;
   logic                lfsr_load_c, lfsr_en_c;
   int unsigned         nsurv_c;
   logic [IW-1:0]       win_c;

   // Key implied by the current symbol if it is a preamble character.
   assign obs_key_c   = PRE_KEY ^ rdata[LW-1:0];
   assign lfsr_load_c = sym_vld_q && (sym_cnt_q == '0);
   assign lfsr_en_c   = sym_vld_q && (sym_cnt_q != '0);

   for (genvar g = 0; g < NTAP; g++) begin : g_lfsr
      lfsr_n #(.LW(LW)) u_lfsr (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (lfsr_en_c),
         .load  (lfsr_load_c),
         .taps  (taps_q[g*LW +: LW]),
         .start (obs_key_c),
         .state (lfsr_state[g])
      );
   end

   always_comb begin
      match_c = '0;
      for (int i = 0; i < NTAP; i++) match_c[i] = (lfsr_state[i] == obs_key_c);
   end

   assign surv_c    = alive_q & match_c;
   assign nsurv_c   = popcount(MAXN'(surv_c));
   assign win_c     = IW'(onehot_idx(MAXN'(surv_c)));
   assign key_sel_c = lfsr_state[sel_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rd_act_q  <= 1'b0;
         sym_vld_q <= 1'b0;
         rd_cnt_q  <= '0;
         sym_cnt_q <= '0;
         alive_q   <= '1;
         taps_q    <= '0;
         raddr     <= '0;
         waddr     <= '0;
         wdata     <= '0;
         wr_en     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         sel_idx   <= '0;
      end else begin
         state_q   <= state_d;
         rd_act_q  <= rd_act_d;
         sym_vld_q <= sym_vld_d;
         rd_cnt_q  <= rd_cnt_d;
         sym_cnt_q <= sym_cnt_d;
         alive_q   <= alive_d;
         taps_q    <= taps_d;
         raddr     <= raddr_d;
         waddr     <= waddr_d;
         wdata     <= wdata_d;
         wr_en     <= wr_en_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
         sel_idx   <= sel_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_act_d  = rd_act_q;
      sym_vld_d = rd_act_q;
      rd_cnt_d  = rd_cnt_q;
      sym_cnt_d = sym_cnt_q;
      alive_d   = alive_q;
      taps_d    = taps_q;
      raddr_d   = raddr;
      waddr_d   = waddr;
      wdata_d   = wdata;
      wr_en_d   = 1'b0;
      busy_d    = busy;
      done_d    = 1'b0;
      err_d     = err;
      sel_idx_d = sel_idx;

      // One read per cycle until every symbol has been requested.
      if (rd_act_q) begin
         if (rd_cnt_q == CW'(MSG_LEN)) begin
            rd_act_d = 1'b0;
         end else begin
            raddr_d  = raddr + AW'(1);
            rd_cnt_d = rd_cnt_q + CW'(1);
         end
      end
      if (sym_vld_q) sym_cnt_d = sym_cnt_q + CW'(1);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_READ_PRE;
               rd_act_d  = 1'b1;
               raddr_d   = SRC_BASE;
               rd_cnt_d  = CW'(1);
               sym_cnt_d = '0;
               alive_d   = '1;
               taps_d    = taps;
               busy_d    = 1'b1;
               err_d     = 1'b0;
               sel_idx_d = '0;
            end
         end
         ST_READ_PRE: begin
            if (sym_vld_q && (sym_cnt_q != '0)) begin
               alive_d = surv_c;
               if (sym_cnt_q == CW'(PRE_LEN - 1)) begin
                  if (nsurv_c == 32'd1) begin
                     state_d   = ST_READ_MSG;
                     sel_idx_d = win_c;
                  end else begin
                     state_d   = ST_FAIL;
                     rd_act_d  = 1'b0;
                     busy_d    = 1'b0;
                     done_d    = 1'b1;
                     err_d     = 1'b1;
                     sel_idx_d = '0;
                  end
               end
            end
         end
         ST_READ_MSG: begin
            if (sym_vld_q) begin
               wr_en_d = 1'b1;
               waddr_d = DST_BASE + AW'(sym_cnt_q) - AW'(PRE_LEN);
               wdata_d = rdata ^ DW'(key_sel_c);
            end else begin
               // Symbol stream drained: the last write is on the bus this cycle.
               state_d = ST_FINISH;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b0;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         ST_FAIL:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

endmodule
